// File: rtl/opcap_pkg.sv
// Shared types and constants for the operand capture stage feeding the a>b comparator.
package opcap_pkg;

   localparam int OPCAP_WIDTH = 2;

   localparam logic [1:0] LED_WAIT_A = 2'b00;
   localparam logic [1:0] LED_WAIT_B = 2'b01;
   localparam logic [1:0] LED_VALID  = 2'b10;

   // The state encoding doubles as the LED pattern, so keep them tied together.
   typedef enum logic [1:0] {
      WAIT_A = LED_WAIT_A,
      WAIT_B = LED_WAIT_B,
      VALID  = LED_VALID
   } state_t;

endpackage

// File: rtl/operand_capture_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, optional debouncer and a one-cycle press pulse.
// The debounce counter exists only when OPCAP_DEBOUNCE_EN is defined.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
      $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
   end

   logic       sync1_q;
   logic       sync2_q;
   logic [1:0] fill_q;
   logic       armed_q;
   logic       level;
   logic       level_prev_q;
   logic       press_q;

   // armed_q blocks the event from a button that was already held through reset;
   // it sets only once a genuine low sample has passed through the synchroniser.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         fill_q       <= 2'b00;
         armed_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= btn;
         sync2_q      <= sync1_q;
         fill_q       <= {fill_q[0], 1'b1};
         if (fill_q[1] && !sync2_q) begin
            armed_q <= 1'b1;
         end
         level_prev_q <= level;
         press_q      <= level & ~level_prev_q & armed_q;
      end
   end

`ifdef OPCAP_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;

   // Counter stops at CNT_LAST and clears, so it can never wrap.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
`else
   assign level = sync2_q;
`endif

   assign press = press_q;

endmodule

// File: rtl/operand_capture.sv
// Captures operand A then B from switches on successive button presses for the a>b comparator.
// Define OPCAP_DEBOUNCE_EN to debounce the button; otherwise the synchronised button is used as-is.
module operand_capture
   import opcap_pkg::*;
#(
   parameter int WIDTH           = OPCAP_WIDTH,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn,
   input  logic             clr,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             operands_valid,
   output logic [1:0]       state_led
);

   logic [WIDTH-1:0] sw_sync1_q;
   logic [WIDTH-1:0] sw_sync2_q;
   logic             press;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic             valid_q;
   logic             valid_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk  (clk),
      .reset(reset),
      .btn  (btn),
      .press(press)
   );

   // Switches need no debounce: they are only sampled on a press event.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
      end else begin
         sw_sync1_q <= sw;
         sw_sync2_q <= sw_sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      if (clr) begin
         state_d = WAIT_A;
         a_d     = '0;
         b_d     = '0;
      end else begin
         case (state_q)
            WAIT_A: if (press) begin
               a_d     = sw_sync2_q;
               state_d = WAIT_B;
            end
            WAIT_B: if (press) begin
               b_d     = sw_sync2_q;
               state_d = VALID;
            end
            // B is left stale on recapture; valid drops until it is taken again.
            VALID: if (press) begin
               a_d     = sw_sync2_q;
               state_d = WAIT_B;
            end
            default: begin
               state_d = WAIT_A;
               a_d     = '0;
               b_d     = '0;
            end
         endcase
      end
      valid_d = (state_d == VALID);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_A;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
      end
   end

   assign a_out          = a_q;
   assign b_out          = b_q;
   assign operands_valid = valid_q;
   assign state_led      = state_q;

endmodule

// File: tb/tb_operand_capture.sv
// Scoreboard bench for operand_capture: stimulus queues expected output changes, a monitor checks them.
module tb_operand_capture;

   localparam int DB = 4;
`ifdef OPCAP_DEBOUNCE_EN
   localparam int LAT = 2 + DB + 1;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic       clr;
   logic [1:0] sw;
   logic [1:0] a_out;
   logic [1:0] b_out;
   logic       operands_valid;
   logic [1:0] state_led;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;
   logic [6:0] prev;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic       v;
      logic [1:0] st;
      int         cyc;
      string      tag;
   } exp_t;

   exp_t sb[$];

   operand_capture #(
      .WIDTH          (2),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sw            (sw),
      .btn           (btn),
      .clr           (clr),
      .a_out         (a_out),
      .b_out         (b_out),
      .operands_valid(operands_valid),
      .state_led     (state_led)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic expect_out(input logic [1:0] ea, input logic [1:0] eb, input logic ev,
                             input logic [1:0] est, input int ecyc, input string tag);
      exp_t e;
      e.a   = ea;
      e.b   = eb;
      e.v   = ev;
      e.st  = est;
      e.cyc = ecyc;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Clean press: btn high 10 cycles then low 10; the capture lands LAT+1 edges after the rise.
   task automatic press(input logic [1:0] swv, input logic [1:0] ea, input logic [1:0] eb,
                        input logic ev, input logic [1:0] est, input string tag);
      @(posedge clk);
      #1;
      sw  = swv;
      btn = 1'b1;
      expect_out(ea, eb, ev, est, cyc + LAT + 1, tag);
      repeat (10) @(posedge clk);
      #1 btn = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   // Monitor: any change of the output bundle is one transaction.
   initial begin
      exp_t       e;
      logic [6:0] cur;
      forever begin
         @(negedge clk);
         cur = {a_out, b_out, operands_valid, state_led};
         if (mon_en && cur !== prev) begin
            prev = cur;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got a=%b b=%b valid=%b state=%b at cycle %0d, expected no change",
                        a_out, b_out, operands_valid, state_led, cyc);
            end else begin
               e = sb.pop_front();
               $display("txn %s: cycle=%0d a=%b b=%b valid=%b state=%b",
                        e.tag, cyc, a_out, b_out, operands_valid, state_led);
               check({e.tag, "_cycle"}, cyc, e.cyc);
               check({e.tag, "_a"}, int'(a_out), int'(e.a));
               check({e.tag, "_b"}, int'(b_out), int'(e.b));
               check({e.tag, "_valid"}, int'(operands_valid), int'(e.v));
               check({e.tag, "_state"}, int'(state_led), int'(e.st));
               if (e.v) begin
                  check({e.tag, "_a_gt_b"}, int'(a_out > b_out), int'(e.a > e.b));
               end
            end
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      btn   = 1'b0;
      clr   = 1'b0;
      sw    = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_a", int'(a_out), 0);
      check("reset_b", int'(b_out), 0);
      check("reset_valid", int'(operands_valid), 0);
      check("reset_state", int'(state_led), 0);
      prev   = {a_out, b_out, operands_valid, state_led};
      mon_en = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(posedge clk);

      press(2'b10, 2'b10, 2'b00, 1'b0, 2'b01, "capture_a");
      press(2'b01, 2'b10, 2'b01, 1'b1, 2'b10, "capture_b");
      press(2'b11, 2'b11, 2'b01, 1'b0, 2'b01, "recapture_a");
      press(2'b10, 2'b11, 2'b10, 1'b1, 2'b10, "recapture_b");
      press(2'b00, 2'b00, 2'b10, 1'b0, 2'b01, "zero_a");

      // clr lands on the same edge as the press event while in WAIT_B.
      @(posedge clk);
      #1;
      sw  = 2'b11;
      btn = 1'b1;
      n   = cyc;
      repeat (LAT) @(posedge clk);
      #1 clr = 1'b1;
      expect_out(2'b00, 2'b00, 1'b0, 2'b00, n + LAT + 1, "clr_collision");
      @(posedge clk);
      #1 clr = 1'b0;
      repeat (10) @(posedge clk);
      #1 btn = 1'b0;
      repeat (12) @(posedge clk);

`ifdef OPCAP_DEBOUNCE_EN
      @(posedge clk);
      #1;
      sw = 2'b01;
      for (int i = 0; i < 10; i++) begin
         btn = ~btn;
         repeat (2) @(posedge clk);
         #1;
      end
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("bounce_state", int'(state_led), 0);
      check("bounce_a", int'(a_out), 0);
`endif

      press(2'b01, 2'b01, 2'b00, 1'b0, 2'b01, "pre_reset_a");

      // Reset while a press is in flight; the still-held button must not fire afterwards.
      @(posedge clk);
      #1;
      btn = 1'b1;
      n   = cyc;
      @(posedge clk);
      #1 reset = 1'b1;
      expect_out(2'b00, 2'b00, 1'b0, 2'b00, n + 2, "reset_mid");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (15) @(posedge clk);
      #1 btn = 1'b0;
      repeat (12) @(posedge clk);

      press(2'b11, 2'b11, 2'b00, 1'b0, 2'b01, "after_reset_a");

      repeat (20) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
